fetch_stage: RTL and testbench

Instruction-fetch stage of the 32-bit MIPS pipeline. It owns the program counter and drives the byte address into the asynchronous-read, big-endian instruction memory. It captures the returned 32-bit word into the IF/ID pipeline register. It also applies stall, flush and redirect requests from the hazard unit, ID-stage jump decode and EX-stage branch resolution.

---
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and fills IF/ID.
// Applies redirects (branch, jump), load-use stalls and a sticky PC fault halt.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        pc_fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] LastAddr = 32'(IMEM_BYTES - 4);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pcPlus4;
  logic        pcIllegal;

  assign pcPlus4   = pc_q + 32'd4;
  assign pcIllegal = (pc_q[1:0] != 2'b00) || (pc_q > LastAddr);

  // Priority: branch redirect, jump, stall, fault halt, normal fetch.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    fault_d = fault_q;
    count_d = count_q;
    if (branch_taken) begin
      pc_d    = branch_target;
      instr_d = 32'd0;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (jump && !stall) begin
      pc_d    = {pc4_q[31:28], jump_index, 2'b00};
      instr_d = 32'd0;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (fault_q || pcIllegal) begin
      fault_d = 1'b1;
      instr_d = 32'd0;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else begin
      pc_d    = pcPlus4;
      instr_d = imem_data;
      pc4_d   = pcPlus4;
      valid_d = 1'b1;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign pc_fault    = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table of per-edge inputs and expected
// register state, plus hand-written sequences for multi-cycle corners.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jump;
  logic [25:0] jumpIndex;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic [31:0] ifIdInstr;
  logic [31:0] ifIdPc4;
  logic        ifIdValid;
  logic        pcFault;
  logic [31:0] fetchCount;

  int checks;
  int failures;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        br;
    logic [31:0] tgt;
    logic        jmp;
    logic [25:0] idx;
    logic [31:0] expPc;
    logic [31:0] expInstr;
    logic [31:0] expPc4;
    logic        expValid;
    logic        expFault;
    logic [31:0] expCount;
  } vec_t;

  vec_t vecs[$];

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_BYTES(128)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branchTaken),
    .branch_target(branchTarget),
    .jump         (jump),
    .jump_index   (jumpIndex),
    .imem_addr    (imemAddr),
    .imem_data    (imemData),
    .if_id_instr  (ifIdInstr),
    .if_id_pc4    (ifIdPc4),
    .if_id_valid  (ifIdValid),
    .pc_fault     (pcFault),
    .fetch_count  (fetchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: two real words at 0 and 4, elsewhere a word tagged with its address.
  always_comb begin
    if (imemAddr == 32'd0)
      imemData = 32'h0001_1020;
    else if (imemAddr == 32'd4)
      imemData = 32'h0002_1820;
    else if (imemAddr < 32'd128)
      imemData = 32'hA000_0000 | {25'd0, imemAddr[6:2], 2'b00};
    else
      imemData = 32'hDEAD_BEEF;
  end

  function automatic vec_t mk(input logic rst, input logic stl, input logic br,
                              input logic [31:0] tgt, input logic jmp, input logic [25:0] idx,
                              input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid,
                              input logic fault, input logic [31:0] count);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.tgt = tgt; v.jmp = jmp; v.idx = idx;
    v.expPc = pc; v.expInstr = instr; v.expPc4 = pc4;
    v.expValid = valid; v.expFault = fault; v.expCount = count;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic stl, input logic br,
                               input logic [31:0] tgt, input logic jmp,
                               input logic [25:0] idx);
    reset        = rst;
    stall        = stl;
    branchTaken  = br;
    branchTarget = tgt;
    jump         = jmp;
    jumpIndex    = idx;
  endtask

  task automatic checkState(input string tag, input vec_t v);
    checkOutput({tag, ".pc"},    imemAddr,           v.expPc);
    checkOutput({tag, ".instr"}, ifIdInstr,          v.expInstr);
    checkOutput({tag, ".pc4"},   ifIdPc4,            v.expPc4);
    checkOutput({tag, ".valid"}, {31'd0, ifIdValid}, {31'd0, v.expValid});
    checkOutput({tag, ".fault"}, {31'd0, pcFault},   {31'd0, v.expFault});
    checkOutput({tag, ".count"}, fetchCount,         v.expCount);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);

    //              rst  stl  br   tgt          jmp  idx    pc           instr          pc4          v    f    count
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,    1'b0,26'h0, 32'h00,     32'h0,         32'h00,     1'b0,1'b0,32'd0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,    1'b0,26'h0, 32'h04,     32'h0001_1020, 32'h04,     1'b1,1'b0,32'd1));
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,    1'b0,26'h0, 32'h08,     32'h0002_1820, 32'h08,     1'b1,1'b0,32'd2));
    vecs.push_back(mk(1'b1,1'b1,1'b0,32'h0,    1'b0,26'h0, 32'h08,     32'h0002_1820, 32'h08,     1'b1,1'b0,32'd2));
    vecs.push_back(mk(1'b1,1'b1,1'b0,32'h0,    1'b0,26'h0, 32'h08,     32'h0002_1820, 32'h08,     1'b1,1'b0,32'd2));
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,    1'b0,26'h0, 32'h0C,     32'hA000_0008, 32'h0C,     1'b1,1'b0,32'd3));
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,    1'b1,26'h2, 32'h08,     32'h0,         32'h00,     1'b0,1'b0,32'd3));
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,    1'b0,26'h0, 32'h0C,     32'hA000_0008, 32'h0C,     1'b1,1'b0,32'd4));
    vecs.push_back(mk(1'b1,1'b1,1'b1,32'h28,   1'b1,26'h5, 32'h28,     32'h0,         32'h00,     1'b0,1'b0,32'd4));
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,    1'b0,26'h0, 32'h2C,     32'hA000_0028, 32'h2C,     1'b1,1'b0,32'd5));
    vecs.push_back(mk(1'b1,1'b0,1'b1,32'h7E,   1'b0,26'h0, 32'h7E,     32'h0,         32'h00,     1'b0,1'b0,32'd5));
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,    1'b0,26'h0, 32'h7E,     32'h0,         32'h00,     1'b0,1'b1,32'd5));
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,    1'b0,26'h0, 32'h7E,     32'h0,         32'h00,     1'b0,1'b1,32'd5));
    vecs.push_back(mk(1'b1,1'b0,1'b1,32'h10,   1'b0,26'h0, 32'h10,     32'h0,         32'h00,     1'b0,1'b1,32'd5));
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,    1'b0,26'h0, 32'h10,     32'h0,         32'h00,     1'b0,1'b1,32'd5));
    vecs.push_back(mk(1'b1,1'b1,1'b0,32'h0,    1'b0,26'h0, 32'h10,     32'h0,         32'h00,     1'b0,1'b1,32'd5));
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'h40,   1'b1,26'h3, 32'h00,     32'h0,         32'h00,     1'b0,1'b0,32'd0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,    1'b0,26'h0, 32'h04,     32'h0001_1020, 32'h04,     1'b1,1'b0,32'd1));
    vecs.push_back(mk(1'b1,1'b0,1'b1,32'h7C,   1'b0,26'h0, 32'h7C,     32'h0,         32'h00,     1'b0,1'b0,32'd1));
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,    1'b0,26'h0, 32'h80,     32'hA000_007C, 32'h80,     1'b1,1'b0,32'd2));
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,    1'b0,26'h0, 32'h80,     32'h0,         32'h00,     1'b0,1'b1,32'd2));
    vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,    1'b0,26'h0, 32'h00,     32'h0,         32'h00,     1'b0,1'b0,32'd0));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].tgt, vecs[i].jmp, vecs[i].idx);
      @(posedge clk);
      #1;
      checkState($sformatf("vec%0d", i), vecs[i]);
    end

    // imem_addr must come straight from the PC register, untouched by redirect inputs mid-cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    @(posedge clk);
    #1;
    checkOutput("seqA.pc", imemAddr, 32'h04);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 26'h9);
    #2;
    checkOutput("seqA.noComb", imemAddr, 32'h04);
    @(posedge clk);
    #1;
    checkOutput("seqA.redirect", imemAddr, 32'h40);

    // Three-cycle stall on a bubble holds everything, then the target is fetched.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("seqB.pc%0d", k), imemAddr, 32'h40);
      checkOutput($sformatf("seqB.valid%0d", k), {31'd0, ifIdValid}, 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
    @(posedge clk);
    #1;
    checkOutput("seqB.pc", imemAddr, 32'h44);
    checkOutput("seqB.instr", ifIdInstr, 32'hA000_0040);
    checkOutput("seqB.count", fetchCount, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
